// File: rtl/mips_boot_ctrl.sv
// Boot/run sequencer for the pipelined MIPS core: clears the register file,
// streams a program into the instruction ROM, flushes the pipeline with PC=0, then runs.
//
// state | meaning
// CLEAR | writing zero to register file entries 0..NREGS-1, one per cycle
// LOAD  | accepting program words into ROM from address 0
// FLUSH | pipeline frozen, PC forced to 0, PIPE_DEPTH bubble cycles
// RUN   | core released
module mips_boot_ctrl #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int NREGS      = 32,
  parameter int PIPE_DEPTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_valid,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic                       ld_last,
  output logic                       ld_ready,
  input  logic                       start,
  input  logic                       stop,
  output logic                       rom_we,
  output logic [ADDR_W-1:0]          rom_waddr,
  output logic [DATA_W-1:0]          rom_wdata,
  output logic                       rf_we,
  output logic [$clog2(NREGS)-1:0]   rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic                       pc_load,
  output logic [31:0]                pc_value,
  output logic                       cpu_run,
  output logic [ADDR_W:0]            prog_len,
  output logic                       ovf
);

  localparam int RW = $clog2(NREGS);
  localparam int FW = $clog2(PIPE_DEPTH + 1);
  localparam logic [RW-1:0] CLR_LAST = RW'(NREGS - 1);
  localparam logic [FW-1:0] FL_INIT  = FW'(PIPE_DEPTH - 1);

  typedef enum logic [1:0] {CLEAR, LOAD, FLUSH, RUN} state_t;

  state_t          state;
  logic [RW-1:0]   clr_cnt;
  logic [FW-1:0]   fl_cnt;
  logic            closed;
  logic            full;
  logic            accept;

  // prog_len saturates at 2**ADDR_W, so its top bit alone flags a full ROM
  assign full      = prog_len[ADDR_W];
  assign ld_ready  = (state == LOAD) && !closed && !full;
  assign accept    = ld_valid && ld_ready;

  assign rom_we    = accept;
  assign rom_waddr = prog_len[ADDR_W-1:0];
  assign rom_wdata = ld_data;

  assign rf_we     = (state == CLEAR);
  assign rf_waddr  = clr_cnt;
  assign rf_wdata  = '0;

  assign pc_load   = (state == FLUSH);
  assign pc_value  = '0;
  assign cpu_run   = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      fl_cnt   <= '0;
      prog_len <= '0;
      closed   <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == CLR_LAST) state <= LOAD;
          else                     clr_cnt <= clr_cnt + 1'b1;
        end
        LOAD: begin
          if (ld_valid && full && !closed) ovf <= 1'b1;
          if (accept) begin
            prog_len <= prog_len + 1'b1;
            if (ld_last) closed <= 1'b1;
          end
          // a word accepted alongside start counts toward a non-empty program
          if (start && (prog_len != '0 || accept)) begin
            state  <= FLUSH;
            fl_cnt <= FL_INIT;
          end
        end
        FLUSH: begin
          if (fl_cnt == '0) state <= RUN;
          else              fl_cnt <= fl_cnt - 1'b1;
        end
        RUN: begin
          if (stop) begin
            state    <= LOAD;
            prog_len <= '0;
            ovf      <= 1'b0;
            closed   <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Self-checking bench for mips_boot_ctrl: directed scenarios plus a random soak,
// each cycle compared against a behavioural model of the boot sequence.
module tb_mips_boot_ctrl;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 32;
  localparam int NREGS      = 32;
  localparam int PIPE_DEPTH = 5;
  localparam int DEPTH      = 2 ** ADDR_W;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     ld_valid;
  logic [DATA_W-1:0]        ld_data;
  logic                     ld_last;
  logic                     ld_ready;
  logic                     start;
  logic                     stop;
  logic                     rom_we;
  logic [ADDR_W-1:0]        rom_waddr;
  logic [DATA_W-1:0]        rom_wdata;
  logic                     rf_we;
  logic [$clog2(NREGS)-1:0] rf_waddr;
  logic [31:0]              rf_wdata;
  logic                     pc_load;
  logic [31:0]              pc_value;
  logic                     cpu_run;
  logic [ADDR_W:0]          prog_len;
  logic                     ovf;

  int checks = 0;
  int errors = 0;

  // model of the sequencer: clearing, loading, flushing or running
  bit m_clr;
  int m_idx;
  int m_len;
  bit m_closed;
  bit m_ovf;
  int m_flush;
  bit m_run;

  mips_boot_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREGS(NREGS), .PIPE_DEPTH(PIPE_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .start(start), .stop(stop),
    .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_load(pc_load), .pc_value(pc_value), .cpu_run(cpu_run),
    .prog_len(prog_len), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_clr    = 1'b1;
    m_idx    = 0;
    m_len    = 0;
    m_closed = 1'b0;
    m_ovf    = 1'b0;
    m_flush  = 0;
    m_run    = 1'b0;
  endtask

  task automatic cyc(input bit r, input bit v, input logic [31:0] d,
                     input bit l, input bit s, input bit p);
    bit loading, rdy, wexp;
    rst = r; ld_valid = v; ld_data = d; ld_last = l; start = s; stop = p;
    @(negedge clk);
    loading = !m_clr && m_flush == 0 && !m_run;
    rdy     = loading && !m_closed && m_len < DEPTH;
    wexp    = rdy && v;
    check("rf_we", 64'(rf_we), 64'(m_clr));
    if (m_clr) check("rf_waddr", 64'(rf_waddr), 64'(m_idx));
    check("rf_wdata", 64'(rf_wdata), 64'(0));
    check("ld_ready", 64'(ld_ready), 64'(rdy));
    check("rom_we", 64'(rom_we), 64'(wexp));
    if (wexp) begin
      check("rom_waddr", 64'(rom_waddr), 64'(m_len));
      check("rom_wdata", 64'(rom_wdata), 64'(d));
    end
    check("pc_load", 64'(pc_load), 64'(m_flush > 0));
    check("pc_value", 64'(pc_value), 64'(0));
    check("cpu_run", 64'(cpu_run), 64'(m_run));
    check("prog_len", 64'(prog_len), 64'(m_len));
    check("ovf", 64'(ovf), 64'(m_ovf));
    @(posedge clk);
    if (r) model_reset();
    else if (m_clr) begin
      if (m_idx == NREGS - 1) m_clr = 1'b0;
      else                    m_idx++;
    end else if (m_flush > 0) begin
      m_flush--;
      if (m_flush == 0) m_run = 1'b1;
    end else if (m_run) begin
      if (p) begin
        m_run = 1'b0; m_len = 0; m_ovf = 1'b0; m_closed = 1'b0;
      end
    end else begin
      if (v && m_len == DEPTH && !m_closed) m_ovf = 1'b1;
      if (wexp) begin
        m_len++;
        if (l) m_closed = 1'b1;
      end
      if (s && m_len > 0) m_flush = PIPE_DEPTH;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; start = 1'b0; stop = 1'b0;
    @(posedge clk);
    model_reset();
    #1;

    // register-file clear, then load mode
    idle(NREGS + 2);

    // four-word program, extra offers after close, then start
    for (int i = 0; i < 4; i++) cyc(0, 1, $urandom, i == 3, 0, 0);
    cyc(0, 1, $urandom, 0, 0, 0);
    cyc(0, 1, $urandom, 1, 0, 0);
    cyc(0, 0, 32'h0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 32'h0, 0, 0, 1);
    idle(3);
    for (int i = 0; i < 3; i++) cyc(0, 1, $urandom, 0, 1, 0);

    // stop, then overflow by offering more words than the ROM holds
    cyc(0, 0, 32'h0, 0, 0, 1);
    for (int i = 0; i < DEPTH + 3; i++) cyc(0, 1, $urandom, 0, 0, 0);
    cyc(0, 0, 32'h0, 0, 1, 0);
    idle(PIPE_DEPTH + 3);

    // stop, empty start must be ignored
    cyc(0, 0, 32'h0, 0, 0, 1);
    cyc(0, 0, 32'h0, 0, 1, 0);
    idle(3);

    // two-word reload, start coinciding with the last word
    cyc(0, 1, $urandom, 0, 0, 0);
    cyc(0, 1, $urandom, 1, 1, 0);
    idle(PIPE_DEPTH + 3);

    // reset during the second flush cycle
    cyc(0, 0, 32'h0, 0, 0, 1);
    cyc(0, 1, $urandom, 0, 1, 0);
    idle(1);
    cyc(1, 0, 32'h0, 0, 0, 0);
    idle(NREGS + 3);

    // random soak
    for (int i = 0; i < 700; i++)
      cyc(($urandom % 250) == 0, ($urandom % 4) != 0, $urandom,
          ($urandom % 20) == 0, ($urandom % 25) == 0, ($urandom % 15) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
